// File: rtl/fb_stream_pkg.sv
// Pixel-format constants and types shared by the scan-out stages.
package fb_stream_pkg;
  localparam int PIXEL_WIDTH     = 16;
  localparam int PIXELS_PER_WORD = 2;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
endpackage

// File: rtl/fb_raster_counter.sv
// Raster x/y position tracker with start-of-frame, end-of-line and end-of-frame decodes.
module fb_raster_counter #(
  parameter int H_RES = 128,
  parameter int V_RES = 128
) (
  input  logic aclk,
  input  logic resetn,
  input  logic advance,
  input  logic resync,
  output logic sof,
  output logic eol,
  output logic eof
);
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (resync) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign sof = (x == '0) && (y == '0);
  assign eol = (x == X_LAST);
  assign eof = eol && (y == Y_LAST);
endmodule

// File: rtl/fb_stream_unpacker.sv
// Splits 32-bit framebuffer words into a one-pixel-per-beat RGB565 stream with SOF/EOL markers.
// Define FB_STREAM_UNPACKER_FRAME_CHECK_EN to check input tlast against the raster and resync on early tlast.
module fb_stream_unpacker
  import fb_stream_pkg::*;
#(
  parameter int H_RES            = 128,
  parameter int V_RES            = 128,
  parameter int CMD_STREAM_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic                        s_framebuffer_axis_tvalid,
  output logic                        s_framebuffer_axis_tready,
  input  logic                        s_framebuffer_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s_framebuffer_axis_tdata,
  output logic                        m_pixel_axis_tvalid,
  input  logic                        m_pixel_axis_tready,
  output logic [15:0]                 m_pixel_axis_tdata,
  output logic                        m_pixel_axis_tuser,
  output logic                        m_pixel_axis_tlast,
  output logic                        frame_err
);
  logic [CMD_STREAM_WIDTH-1:0] word;
  logic   word_valid;
  logic   half;
  pixel_t pix_lo;
  pixel_t pix_hi;
  logic   pix_hs;
  logic   word_hs;
  logic   word_done;
  logic   resync;
  logic   sof;
  logic   eol;
  logic   eof;

  assign pix_lo    = word[PIXEL_WIDTH-1:0];
  assign pix_hi    = word[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
  assign pix_hs    = word_valid && m_pixel_axis_tready;
  assign word_done = pix_hs && half;

  // Refilling while the high pixel leaves keeps the output at one pixel per clock.
  assign s_framebuffer_axis_tready = resetn && (!word_valid || (half && m_pixel_axis_tready));
  assign word_hs = s_framebuffer_axis_tvalid && s_framebuffer_axis_tready;

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      word_valid <= 1'b0;
      half       <= 1'b0;
      word       <= '0;
    end else if (word_hs) begin
      word       <= s_framebuffer_axis_tdata;
      word_valid <= 1'b1;
      half       <= 1'b0;
    end else if (word_done) begin
      word_valid <= 1'b0;
      half       <= 1'b0;
    end else if (pix_hs) begin
      half <= 1'b1;
    end
  end

`ifdef FB_STREAM_UNPACKER_FRAME_CHECK_EN
  logic word_last;
  logic err;

  // eof on the high pixel is where the frame's last word must sit.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      word_last <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (word_hs) word_last <= s_framebuffer_axis_tlast;
      if (word_done && (word_last != eof)) err <= 1'b1;
    end
  end

  assign resync    = word_done && word_last && !eof;
  assign frame_err = err;
`else
  logic unused_frame_check;
  assign unused_frame_check = eof ^ s_framebuffer_axis_tlast;
  assign resync    = 1'b0;
  assign frame_err = 1'b0;
`endif

  fb_raster_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_raster (
    .aclk   (aclk),
    .resetn (resetn),
    .advance(pix_hs),
    .resync (resync),
    .sof    (sof),
    .eol    (eol),
    .eof    (eof)
  );

  assign m_pixel_axis_tvalid = word_valid;
  assign m_pixel_axis_tdata  = half ? pix_hi : pix_lo;
  assign m_pixel_axis_tuser  = sof;
  assign m_pixel_axis_tlast  = eol;
endmodule

// File: tb/tb_fb_stream_unpacker.sv
// Bench for fb_stream_unpacker: directed frames plus random traffic against a queue-based pixel model.
module tb_fb_stream_unpacker;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FP = H * V;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [15:0] m_tdata;
  logic        m_tuser;
  logic        m_tlast;
  logic        frame_err;

  int tests = 0;
  int failed = 0;

  typedef struct { logic [31:0] data; bit last; } word_t;
  typedef struct { logic [15:0] d; bit sof; bit eol; bit err; } pix_t;

  word_t src_q[$];
  pix_t  exp_q[$];
  int    pos = 0;
  bit    m_err = 0;

  always #5 aclk = ~aclk;

  fb_stream_unpacker #(.H_RES(H), .V_RES(V), .CMD_STREAM_WIDTH(32)) dut (
    .aclk                     (aclk),
    .resetn                   (resetn),
    .s_framebuffer_axis_tvalid(s_tvalid),
    .s_framebuffer_axis_tready(s_tready),
    .s_framebuffer_axis_tlast (s_tlast),
    .s_framebuffer_axis_tdata (s_tdata),
    .m_pixel_axis_tvalid      (m_tvalid),
    .m_pixel_axis_tready      (m_tready),
    .m_pixel_axis_tdata       (m_tdata),
    .m_pixel_axis_tuser       (m_tuser),
    .m_pixel_axis_tlast       (m_tlast),
    .frame_err                (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each accepted word yields two raster positions; frame length rules applied on the high pixel.
  task automatic model_accept(input word_t w);
    pix_t lo, hi;
    lo.d = w.data[15:0];  lo.sof = (pos == 0); lo.eol = ((pos % H) == H - 1); lo.err = 0;
    pos++;
    hi.d = w.data[31:16]; hi.sof = (pos == 0); hi.eol = ((pos % H) == H - 1); hi.err = 0;
    pos++;
`ifdef FB_STREAM_UNPACKER_FRAME_CHECK_EN
    if (w.last && pos != FP) begin
      hi.err = 1;
      pos = 0;
    end else if (!w.last && pos == FP) begin
      hi.err = 1;
    end
`endif
    if (pos == FP) pos = 0;
    exp_q.push_back(lo);
    exp_q.push_back(hi);
  endtask

  task automatic add_frame(input int base, input int last_idx);
    word_t w;
    for (int k = 0; k < 4; k++) begin
      w.data = {16'(base + 2 * k + 2), 16'(base + 2 * k + 1)};
      w.last = (k == last_idx);
      src_q.push_back(w);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    resetn = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hdead_beef; s_tlast = 1'b1; m_tready = 1'b1;
    #1;
    check("rst_s_tready", s_tready, 0);
    @(negedge aclk);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tuser", m_tuser, 1);
    check("rst_tlast", m_tlast, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_s_tready_hold", s_tready, 0);
    resetn = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
    src_q.delete(); exp_q.delete(); pos = 0; m_err = 0;
  endtask

  // rmode: 0 ready high, 1 toggle 1,0,.., 2 random. vmode: 0 valid whenever data, 1 random gaps.
  task automatic run(input int max_cyc, input int rmode, input int vmode, input int stop_pix);
    int cyc = 0;
    int npix = 0;
    bit done = 0;
    bit tog = 1;
    bit exp_valid, exp_sready, acc, take;
    while (!done) begin
      @(negedge aclk);
      if (src_q.size() > 0 && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
        s_tvalid = 1'b1; s_tdata = src_q[0].data; s_tlast = src_q[0].last;
      end else begin
        s_tvalid = 1'b0; s_tdata = $urandom; s_tlast = 1'($urandom_range(0, 1));
      end
      case (rmode)
        0: m_tready = 1'b1;
        1: begin m_tready = tog; tog = !tog; end
        default: m_tready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      exp_valid  = (exp_q.size() > 0);
      exp_sready = (exp_q.size() == 0) || (exp_q.size() == 1 && m_tready);
      check("tvalid", m_tvalid, exp_valid);
      check("s_tready", s_tready, exp_sready);
      check("frame_err", frame_err, m_err);
      if (exp_valid) begin
        check("tdata", m_tdata, exp_q[0].d);
        check("tuser", m_tuser, exp_q[0].sof);
        check("tlast", m_tlast, exp_q[0].eol);
      end
      acc  = s_tvalid && exp_sready;
      take = exp_valid && m_tready;
      @(posedge aclk);
      if (take) begin
        if (exp_q[0].err) m_err = 1;
        void'(exp_q.pop_front());
        npix++;
      end
      if (acc) begin
        model_accept(src_q[0]);
        void'(src_q.pop_front());
      end
      cyc++;
      if (stop_pix > 0 ? (npix >= stop_pix) : (src_q.size() == 0 && exp_q.size() == 0)) begin
        done = 1;
      end else begin
        tests++;
        assert (cyc < max_cyc) else begin
          failed++;
          $error("FAIL cycle_budget observed=%0d expected<%0d", cyc, max_cyc);
          done = 1;
        end
      end
    end
    @(negedge aclk);
    s_tvalid = 1'b0;
  endtask

  initial begin
    word_t w;
    do_reset();
    add_frame(0, 3);
    run(40, 0, 0, 0);

    do_reset();
    add_frame(0, 3);
    run(60, 1, 0, 0);

    do_reset();
    add_frame(0, 3);
    add_frame(16'h10, 3);
    run(60, 0, 0, 0);

    do_reset();
    add_frame(0, 1);
    add_frame(16'h20, 3);
    run(60, 0, 0, 0);

    do_reset();
    add_frame(0, -1);
    add_frame(16'h30, 3);
    run(60, 0, 0, 0);

    do_reset();
    add_frame(0, 3);
    run(40, 0, 0, 3);
    do_reset();
    add_frame(16'h40, 3);
    run(40, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 48; i++) begin
      w.data = $urandom;
      w.last = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : ((i % 4) == 3);
      src_q.push_back(w);
    end
    run(2000, 2, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
